// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate element.
//   res_width : width of the accumulator/result for given sample/coef widths
//   sat_clamp : clamps a wide signed sum into a signed field of 'width' bits
package mac_pkg;

  function automatic int res_width(input int img_w, input int ker_w);
    return img_w + ker_w + 1;
  endfunction

  // Works on a 64-bit carrier so one helper serves any result width up to 63.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] sum,
                                                   input int               width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (sum > max_v)
      return max_v;
    else if (sum < min_v)
      return min_v;
    else
      return sum;
  endfunction

endpackage

// File: rtl/mac_mult.sv
// Two-stage registered signed multiplier with valid pipeline.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset, clears all stages
//   val      : input valid
//   img, ker : signed sample / coefficient
//   prod     : registered full-precision product (IMG_WIDTH+KER_WIDTH bits)
//   prod_vld : valid flag travelling with prod
module mac_mult #(
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  val,
  input  logic signed [IMG_WIDTH-1:0]           img,
  input  logic signed [KER_WIDTH-1:0]           ker,
  output logic signed [IMG_WIDTH+KER_WIDTH-1:0] prod,
  output logic                                  prod_vld
);

  localparam int PROD_W = IMG_WIDTH + KER_WIDTH;

  logic signed [IMG_WIDTH-1:0] img_p0;
  logic signed [KER_WIDTH-1:0] ker_p0;
  logic                        vld_p0;
  logic signed [PROD_W-1:0]    prod_c;
  logic signed [PROD_W-1:0]    prod_p1;
  logic                        vld_p1;

  // S1: input capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_p0 <= '0;
      ker_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      img_p0 <= img;
      ker_p0 <= ker;
      vld_p0 <= val;
    end
  end

  assign prod_c = PROD_W'(img_p0) * PROD_W'(ker_p0);

  // S2: product register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      prod_p1 <= prod_c;
      vld_p1  <= vld_p0;
    end
  end

  assign prod     = prod_p1;
  assign prod_vld = vld_p1;

endmodule

// File: rtl/multiply_acc.sv
// Signed multiply-accumulate element for the convolution datapath.
// Products of a contiguous run of valid beats are summed with saturation;
// the result register holds its value between bursts.
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   val    : input valid
//   img    : signed image sample (IMG_WIDTH)
//   ker    : signed kernel coefficient (KER_WIDTH)
//   result : registered saturated running sum (IMG_WIDTH+KER_WIDTH+1)
module multiply_acc
  import mac_pkg::*;
#(
  parameter  int IMG_WIDTH = 16,
  parameter  int KER_WIDTH = 8,
  localparam int RES_WIDTH = res_width(IMG_WIDTH, KER_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        val,
  input  logic signed [IMG_WIDTH-1:0] img,
  input  logic signed [KER_WIDTH-1:0] ker,
  output logic signed [RES_WIDTH-1:0] result
);

  localparam int PROD_W = IMG_WIDTH + KER_WIDTH;

  logic signed [PROD_W-1:0]    prod_p1;
  logic                        vld_p1;
  logic                        vld_p2;
  logic signed [RES_WIDTH-1:0] acc_p2;
  logic signed [RES_WIDTH:0]   sum_p2;

  function automatic logic signed [RES_WIDTH-1:0] sat_acc(input logic signed [RES_WIDTH:0] sum);
    return RES_WIDTH'(sat_clamp(64'(sum), RES_WIDTH));
  endfunction

  mac_mult #(
    .IMG_WIDTH (IMG_WIDTH),
    .KER_WIDTH (KER_WIDTH)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .val      (val),
    .img      (img),
    .ker      (ker),
    .prod     (prod_p1),
    .prod_vld (vld_p1)
  );

  // One guard bit above the accumulator catches overflow in either direction.
  assign sum_p2 = (RES_WIDTH+1)'(acc_p2) + (RES_WIDTH+1)'(prod_p1);

  // S3: accumulate; vld_p2 remembers whether the previous S2 cycle was valid,
  // so a valid beat after any idle cycle restarts the sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p2 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1)
        acc_p2 <= vld_p2 ? sat_acc(sum_p2) : RES_WIDTH'(prod_p1);
    end
  end

  assign result = acc_p2;

endmodule

// File: tb/tb_multiply_acc.sv
module tb_multiply_acc;

  localparam int IMG_W = 16;
  localparam int KER_W = 8;
  localparam int RES_W = IMG_W + KER_W + 1;
  localparam longint MAXV = (64'sd1 <<< (RES_W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (RES_W - 1));

  logic                    clk;
  logic                    rst;
  logic                    val;
  logic signed [IMG_W-1:0] img;
  logic signed [KER_W-1:0] ker;
  logic signed [RES_W-1:0] result;

  int total;
  int bad;

  logic signed [RES_W-1:0] sb_q[$];
  longint                  m_acc;
  bit                      m_prev;

  multiply_acc #(
    .IMG_WIDTH (IMG_W),
    .KER_WIDTH (KER_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .val    (val),
    .img    (img),
    .ker    (ker),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [RES_W-1:0] obs,
                       input logic signed [RES_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model is restarted alongside the DUT; the first two results after reset are 0.
  task automatic model_reset();
    m_acc  = 0;
    m_prev = 1'b0;
    sb_q.delete();
    sb_q.push_back('0);
    sb_q.push_back('0);
  endtask

  // Drive one cycle, push the model's value for this beat, then compare the
  // result that the scoreboard says is due after this edge.
  task automatic step(input bit v, input int i, input int k);
    longint p;
    longint s;
    val = v;
    img = v ? IMG_W'(i) : IMG_W'($urandom);
    ker = v ? KER_W'(k) : KER_W'($urandom);
    if (v) begin
      p = longint'(i) * longint'(k);
      if (!m_prev) begin
        m_acc = p;
      end else begin
        s = m_acc + p;
        m_acc = (s > MAXV) ? MAXV : (s < MINV) ? MINV : s;
      end
    end
    m_prev = v;
    sb_q.push_back(RES_W'(m_acc));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=%0d expected=queue_entry", result);
    end else begin
      check("sb", result, sb_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    val   = 1'b0;
    img   = '0;
    ker   = '0;

    // reset held with random activity on the inputs
    for (int j = 0; j < 6; j++) begin
      val = 1'($urandom);
      img = IMG_W'($urandom);
      ker = KER_W'($urandom);
      @(posedge clk);
      #1;
      check("rst_hold", result, '0);
    end
    rst = 1'b1;
    model_reset();

    // continuous burst, alternating sign
    for (int j = 1; j <= 10; j++) step(1'b1, (j % 2 == 1) ? -1 : 1, j);
    idle(2);
    check("burst10", result, 25'sd5);
    idle(3);
    check("burst10_hold", result, 25'sd5);

    // bursts separated by gaps
    for (int j = 1; j <= 5; j++) step(1'b1, 1, j);
    idle(2);
    check("burst_1_5", result, 25'sd15);
    idle(1);
    step(1'b1, 1, 6);
    idle(2);
    check("single_6", result, 25'sd6);
    idle(2);
    check("single_6_hold", result, 25'sd6);
    for (int j = 7; j <= 11; j++) step(1'b1, 1, j);
    idle(1);
    step(1'b1, 1, 12);
    check("burst_7_11", result, 25'sd45);
    for (int j = 13; j <= 31; j++) step(1'b1, 1, j);
    idle(2);
    check("burst_12_31", result, 25'sd430);
    idle(2);

    // positive saturation
    for (int j = 0; j < 4; j++) step(1'b1, -32768, -128);
    step(1'b1, -1, 1);
    idle(1);
    check("pos_sat", result, 25'sd16777215);
    idle(1);
    check("pos_sat_sub", result, 25'sd16777214);
    idle(2);

    // negative saturation
    for (int j = 0; j < 5; j++) step(1'b1, -32768, 127);
    idle(2);
    check("neg_sat", result, -25'sd16777216);
    idle(2);

    // latency and don't-care inputs while idle
    step(1'b1, 3, -2);
    check("lat_k", result, -25'sd16777216);
    idle(1);
    check("lat_k1", result, -25'sd16777216);
    idle(1);
    check("lat_k2", result, -25'sd6);
    idle(6);
    check("dontcare_hold", result, -25'sd6);

    // asynchronous reset in the middle of a burst
    for (int j = 0; j < 3; j++) step(1'b1, 100, 7);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", result, '0);
    for (int j = 0; j < 2; j++) begin
      @(posedge clk);
      #1;
      check("async_rst_hold", result, '0);
    end
    rst = 1'b1;
    model_reset();
    step(1'b1, 2, 3);
    idle(2);
    check("post_rst_beat", result, 25'sd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
